// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the E->M register.
// Optional: define EXEC_MULQ_EN to add OPq ifun 4 (signed mulq).
module execute_stage #(
    parameter logic [2:0]  CC_RESET   = 3'b100,
    parameter logic [63:0] STACK_STEP = 64'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [63:0] E_valC,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [1:0]  E_stat,
    input  logic        m_exc,
    input  logic        W_exc,
    input  logic        M_bubble,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic [3:0]  M_icode,
    output logic [1:0]  M_stat,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM
);

    localparam logic [1:0] StatAok = 2'b00;
    localparam logic [1:0] StatIns = 2'b11;
    localparam logic [3:0] RegNone = 4'hF;

    logic [2:0]  cc_q, cc_d;  // {ZF, SF, OF}
    logic        op_valid;
    logic [63:0] alu_res;
    logic        alu_of;
    logic        set_cc;
    logic        cnd;
    logic        zf, sf, of;

`ifdef EXEC_MULQ_EN
    logic signed [127:0] prod;
    assign prod = $signed({{64{E_valB[63]}}, E_valB}) * $signed({{64{E_valA[63]}}, E_valA});
`endif

    // OPq datapath; unused function codes flag the instruction as invalid.
    always_comb begin
        op_valid = 1'b1;
        alu_res  = '0;
        alu_of   = 1'b0;
        case (E_ifun)
            4'h0: begin
                alu_res = E_valB + E_valA;
                alu_of  = (E_valA[63] == E_valB[63]) && (alu_res[63] != E_valA[63]);
            end
            4'h1: begin
                alu_res = E_valB - E_valA;
                alu_of  = (E_valA[63] != E_valB[63]) && (alu_res[63] != E_valB[63]);
            end
            4'h2: alu_res = E_valB & E_valA;
            4'h3: alu_res = E_valB ^ E_valA;
`ifdef EXEC_MULQ_EN
            4'h4: begin
                alu_res = prod[63:0];
                alu_of  = !((&prod[127:63]) || !(|prod[127:63]));
            end
`endif
            default: op_valid = 1'b0;
        endcase
    end

    always_comb begin
        case (E_icode)
            4'h2:         e_valE = E_valA;
            4'h3:         e_valE = E_valC;
            4'h4, 4'h5:   e_valE = E_valB + E_valC;
            4'h6:         e_valE = alu_res;
            4'h8, 4'hA:   e_valE = E_valB - STACK_STEP;
            4'h9, 4'hB:   e_valE = E_valB + STACK_STEP;
            default:      e_valE = '0;
        endcase
    end

    assign set_cc = (E_icode == 4'h6) && !m_exc && !W_exc && (E_stat == StatAok) && op_valid;

    always_comb begin
        cc_d = cc_q;
        if (set_cc) cc_d = {alu_res == 64'd0, alu_res[63], alu_of};
    end

    assign {zf, sf, of} = cc_q;

    always_comb begin
        cnd = 1'b0;
        if (E_icode == 4'h2 || E_icode == 4'h7) begin
            case (E_ifun)
                4'h0:    cnd = 1'b1;
                4'h1:    cnd = (sf ^ of) | zf;
                4'h2:    cnd = sf ^ of;
                4'h3:    cnd = zf;
                4'h4:    cnd = !zf;
                4'h5:    cnd = !(sf ^ of);
                4'h6:    cnd = !(sf ^ of) && !zf;
                default: cnd = 1'b0;
            endcase
        end
    end

    assign e_dstE = (E_icode == 4'h2 && !cnd) ? RegNone : E_dstE;

    always_ff @(posedge clk) begin
        if (reset) cc_q <= CC_RESET;
        else       cc_q <= cc_d;
    end

    always_ff @(posedge clk) begin
        if (reset || M_bubble) begin
            M_icode <= 4'h1;
            M_stat  <= StatAok;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RegNone;
            M_dstM  <= RegNone;
        end else begin
            M_icode <= E_icode;
            M_stat  <= (E_stat == StatAok && E_icode == 4'h6 && !op_valid) ? StatIns : E_stat;
            M_Cnd   <= cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed program fragments then random traffic against a
// flag-level reference model that tracks the condition codes across instructions.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
    logic [63:0] E_valA, E_valB, E_valC;
    logic [1:0]  E_stat;
    logic        m_exc, W_exc, M_bubble;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic [3:0]  M_icode;
    logic [1:0]  M_stat;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;

    int unsigned n_cmp  = 0;
    int unsigned n_miss = 0;
    logic [2:0]  cc_model = 3'bxxx;

    execute_stage dut (
        .clk      (clk),
        .reset    (reset),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_valA   (E_valA),
        .E_valB   (E_valB),
        .E_valC   (E_valC),
        .E_dstE   (E_dstE),
        .E_dstM   (E_dstM),
        .E_stat   (E_stat),
        .m_exc    (m_exc),
        .W_exc    (W_exc),
        .M_bubble (M_bubble),
        .e_valE   (e_valE),
        .e_dstE   (e_dstE),
        .M_icode  (M_icode),
        .M_stat   (M_stat),
        .M_Cnd    (M_Cnd),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, check the combinational outputs, clock it, check the M register.
    task automatic apply(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] de, input logic [3:0] dm, input logic [1:0] st,
                         input logic mx, input logic wx, input logic bub, input logic rst);
        logic               valid, of, cnd, zf, sf, cof;
        logic [63:0]        res, vale;
        logic [3:0]         dste;
        logic signed [64:0] s65;
`ifdef EXEC_MULQ_EN
        logic signed [127:0] p;
`endif
        reset = rst; E_icode = icode; E_ifun = ifun; E_valA = a; E_valB = b; E_valC = c;
        E_dstE = de; E_dstM = dm; E_stat = st; m_exc = mx; W_exc = wx; M_bubble = bub;

        valid = 1'b1; res = '0; of = 1'b0;
        case (ifun)
            4'h0: begin
                s65 = $signed({b[63], b}) + $signed({a[63], a});
                res = s65[63:0]; of = s65[64] ^ s65[63];
            end
            4'h1: begin
                s65 = $signed({b[63], b}) - $signed({a[63], a});
                res = s65[63:0]; of = s65[64] ^ s65[63];
            end
            4'h2: res = a & b;
            4'h3: res = a ^ b;
`ifdef EXEC_MULQ_EN
            4'h4: begin
                p = $signed({{64{b[63]}}, b}) * $signed({{64{a[63]}}, a});
                res = p[63:0];
                of = (p != $signed({{64{res[63]}}, res}));
            end
`endif
            default: valid = 1'b0;
        endcase
        if (icode == 4'h6 && !valid) res = '0;

        case (icode)
            4'h2: vale = a;
            4'h3: vale = c;
            4'h4, 4'h5: vale = b + c;
            4'h6: vale = res;
            4'h8, 4'hA: vale = b - 64'd8;
            4'h9, 4'hB: vale = b + 64'd8;
            default: vale = '0;
        endcase

        {zf, sf, cof} = cc_model;
        cnd = 1'b0;
        if (icode == 4'h2 || icode == 4'h7) begin
            case (ifun)
                4'h0: cnd = 1'b1;
                4'h1: cnd = (sf != cof) || zf;
                4'h2: cnd = (sf != cof);
                4'h3: cnd = zf;
                4'h4: cnd = !zf;
                4'h5: cnd = (sf == cof);
                4'h6: cnd = (sf == cof) && !zf;
                default: cnd = 1'b0;
            endcase
        end
        dste = (icode == 4'h2 && !cnd) ? 4'hF : de;

        #1;
        check_eq("e_valE", e_valE, vale);
        check_eq("e_dstE", {60'd0, e_dstE}, {60'd0, dste});

        @(posedge clk);
        #1;
        if (rst || bub) begin
            check_eq("M_icode", {60'd0, M_icode}, 64'd1);
            check_eq("M_stat", {62'd0, M_stat}, 64'd0);
            check_eq("M_Cnd", {63'd0, M_Cnd}, 64'd0);
            check_eq("M_valE", M_valE, 64'd0);
            check_eq("M_valA", M_valA, 64'd0);
            check_eq("M_dstE", {60'd0, M_dstE}, 64'hF);
            check_eq("M_dstM", {60'd0, M_dstM}, 64'hF);
        end else begin
            check_eq("M_icode", {60'd0, M_icode}, {60'd0, icode});
            check_eq("M_stat", {62'd0, M_stat},
                     (st == 2'b00 && icode == 4'h6 && !valid) ? 64'd3 : {62'd0, st});
            check_eq("M_Cnd", {63'd0, M_Cnd}, {63'd0, cnd});
            check_eq("M_valE", M_valE, vale);
            check_eq("M_valA", M_valA, a);
            check_eq("M_dstE", {60'd0, M_dstE}, {60'd0, dste});
            check_eq("M_dstM", {60'd0, M_dstM}, {60'd0, dm});
        end

        if (rst) cc_model = 3'b100;
        else if (icode == 4'h6 && !mx && !wx && st == 2'b00 && valid)
            cc_model = {res == 64'd0, res[63], of};
    endtask

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return '1;
            4: return {60'd0, 4'($urandom)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0] ri, rf;
        logic [1:0] rs;

        // Reset for two cycles, then probe reset CC with jXX e / l.
        apply(4'h0, 4'h0, 0, 0, 0, 4'h3, 4'h4, 2'b00, 0, 0, 0, 1);
        apply(4'h0, 4'h0, 0, 0, 0, 4'h3, 4'h4, 2'b00, 0, 0, 0, 1);
        apply(4'h7, 4'h3, 0, 0, 64'h40, 4'hF, 4'hF, 2'b00, 0, 0, 0, 0);
        apply(4'h7, 4'h2, 0, 0, 64'h40, 4'hF, 4'hF, 2'b00, 0, 0, 0, 0);

        // Signed overflow on add, then observe SF/OF through branches.
        apply(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 4'h2, 4'hF, 2'b00, 0, 0, 0, 0);
        check_eq("add_ovf_valE", M_valE, 64'h8000_0000_0000_0000);
        apply(4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF, 2'b00, 0, 0, 0, 0);
        apply(4'h7, 4'h4, 0, 0, 0, 4'hF, 4'hF, 2'b00, 0, 0, 0, 0);

        // sub 5-5 then cmovle (taken) and cmovne (squashed).
        apply(4'h6, 4'h1, 64'd5, 64'd5, 0, 4'h3, 4'hF, 2'b00, 0, 0, 0, 0);
        apply(4'h2, 4'h1, 64'h11, 0, 0, 4'h6, 4'hF, 2'b00, 0, 0, 0, 0);
        check_eq("cmovle_dstE", {60'd0, M_dstE}, 64'h6);
        apply(4'h2, 4'h4, 64'h11, 0, 0, 4'h6, 4'hF, 2'b00, 0, 0, 0, 0);
        check_eq("cmovne_dstE", {60'd0, M_dstE}, 64'hF);

        // push / pop stack pointer adjust.
        apply(4'hA, 4'h0, 64'h55, 64'h100, 0, 4'h4, 4'hF, 2'b00, 0, 0, 0, 0);
        check_eq("push_valE", M_valE, 64'hF8);
        apply(4'hB, 4'h0, 64'hF8, 64'hF8, 0, 4'h4, 4'h1, 2'b00, 0, 0, 0, 0);
        check_eq("pop_valE", M_valE, 64'h100);

        // sub blocked by m_exc, together with a bubble; CC must stay ZF=1.
        apply(4'h6, 4'h1, 64'd1, 64'd9, 0, 4'h3, 4'hF, 2'b00, 1, 0, 1, 0);
        apply(4'h7, 4'h3, 0, 0, 0, 4'hF, 4'hF, 2'b00, 0, 0, 0, 0);
        check_eq("cc_frozen_mexc", {63'd0, M_Cnd}, 64'd1);

        // ifun 4: mulq when enabled, INS otherwise.
        apply(4'h6, 4'h4, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 4'h3, 4'hF, 2'b00, 0, 0, 0, 0);
        apply(4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF, 2'b00, 0, 0, 0, 0);
        apply(4'h6, 4'h9, 64'd3, 64'd4, 0, 4'h3, 4'hF, 2'b00, 0, 0, 0, 0);
        apply(4'h6, 4'h1, 64'd3, 64'd4, 0, 4'h3, 4'hF, 2'b10, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            ri = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom);
            rf = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            apply(ri, rf, rand_val(), rand_val(), rand_val(), 4'($urandom), 4'($urandom), rs,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
